vblank_scheduler: RTL and testbench

- Schedules game-logic update windows during vertical blanking, using timing pulses from the VGA timing generator.
- Up to NREQ requesters (player, ball, snitch and score update engines) get an exclusive, one-hot grant of the shared frame-state RAM port.
- Arbitration is round-robin. Each requester is served at most once per blanking window.
- Tracks overruns (blanking ends mid-grant) and per-grant timeouts, and keeps a frame counter.

---
 rtl/vblank_scheduler_pkg.sv | 25 ++
 rtl/vblank_scheduler_rr_pick.sv | 30 +++
 rtl/vblank_scheduler.sv | 148 ++++++++++++++
 tb/tb_vblank_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vblank_scheduler_pkg.sv
// Shared types and constants for the vertical-blanking update scheduler.
// Requester indices name the game engines sharing the frame-state RAM port.
package vblank_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2
    } state_e;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 4096;
    localparam int DEF_TCW     = 13;
    localparam int DEF_FCW     = 8;

    localparam int REQ_PLAYER = 0;
    localparam int REQ_BALL   = 1;
    localparam int REQ_SNITCH = 2;
    localparam int REQ_SCORE  = 3;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vblank_scheduler_rr_pick.sv
// Combinational round-robin selector: first pending bit after ptr_i, wrapping.
module rr_pick
    import vblank_scheduler_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] pend_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [PW-1:0]   pick_o,
    output logic            valid_o
);

    logic [PW-1:0] idx;

    // The current pointer is searched last, so the previous winner has lowest priority.
    always_comb begin
        pick_o  = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = PW'((int'(ptr_i) + off) % NREQ);
            if (!valid_o && pend_i[idx]) begin
                valid_o = 1'b1;
                pick_o  = idx;
            end
        end
    end

endmodule

// File: rtl/vblank_scheduler.sv
// Hands out exclusive one-hot grants of the frame-state RAM port during
// vertical blanking, with overrun/timeout tracking and a frame counter.
module vblank_scheduler
    import vblank_scheduler_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TCW     = DEF_TCW,
    parameter int FCW     = DEF_FCW
) (
    input  logic            vgaclk,
    input  logic            inputreset,
    input  logic            pixelstb,
    input  logic            anm,
    input  logic            endscreen,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    input  logic            clr_err,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            frame_tick,
    output logic [FCW-1:0]  frame_cnt,
    output logic            overrun,
    output logic            timeout_err
);

    localparam int PW = ptr_width(NREQ);

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] served_q, served_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [TCW-1:0]  tcnt_q, tcnt_d;
    logic [FCW-1:0]  frame_q, frame_d;
    logic            tick_q, tick_d;
    logic            overrun_q, overrun_d;
    logic            toerr_q, toerr_d;

    logic            anm_ev, end_ev;
    logic [PW-1:0]   pick;
    logic            pick_valid;

    assign anm_ev = anm & pixelstb;
    assign end_ev = endscreen & pixelstb;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .pend_i  (req & ~served_q),
        .ptr_i   (ptr_q),
        .pick_o  (pick),
        .valid_o (pick_valid)
    );

    always_ff @(posedge vgaclk or posedge inputreset) begin
        if (inputreset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            served_q  <= '0;
            ptr_q     <= PW'(NREQ - 1);
            tcnt_q    <= '0;
            frame_q   <= '0;
            tick_q    <= 1'b0;
            overrun_q <= 1'b0;
            toerr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            served_q  <= served_d;
            ptr_q     <= ptr_d;
            tcnt_q    <= tcnt_d;
            frame_q   <= frame_d;
            tick_q    <= tick_d;
            overrun_q <= overrun_d;
            toerr_q   <= toerr_d;
        end
    end

    // Sticky flags are cleared first so a same-cycle set below takes priority.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        served_d  = served_q;
        ptr_d     = ptr_q;
        tcnt_d    = tcnt_q;
        frame_d   = frame_q;
        tick_d    = 1'b0;
        overrun_d = overrun_q & ~clr_err;
        toerr_d   = toerr_q & ~clr_err;

        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (anm_ev) begin
                    served_d = '0;
                    state_d  = ARB;
                end
            end
            ARB: begin
                if (!pick_valid) begin
                    state_d = IDLE;
                end else begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    ptr_d       = pick;
                    tcnt_d      = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                tcnt_d = tcnt_q + TCW'(1);
                if (done[ptr_q]) begin
                    gnt_d           = '0;
                    served_d[ptr_q] = 1'b1;
                    state_d         = ARB;
                end else if (tcnt_q == TCW'(TIMEOUT - 1)) begin
                    gnt_d           = '0;
                    served_d[ptr_q] = 1'b1;
                    toerr_d         = 1'b1;
                    state_d         = ARB;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Window close overrides everything; an aborted grant is not marked served.
        if (end_ev) begin
            tick_d   = 1'b1;
            frame_d  = frame_q + FCW'(1);
            served_d = served_q;
            ptr_d    = ptr_q;
            gnt_d    = '0;
            state_d  = IDLE;
            if (state_q != IDLE) begin
                overrun_d = 1'b1;
            end
        end
    end

    assign gnt         = gnt_q;
    assign busy        = (state_q != IDLE);
    assign frame_tick  = tick_q;
    assign frame_cnt   = frame_q;
    assign overrun     = overrun_q;
    assign timeout_err = toerr_q;

endmodule

// File: tb/tb_vblank_scheduler.sv
// Directed bench for vblank_scheduler: a vector table for the arbitration
// walk-throughs plus hand sequences for timeout, overrun, wrap and reset.
module tb_vblank_scheduler;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;
    localparam int TCW     = 13;
    localparam int FCW     = 2;

    logic            vgaclk;
    logic            inputreset;
    logic            pixelstb;
    logic            anm;
    logic            endscreen;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] done;
    logic            clr_err;
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic            frame_tick;
    logic [FCW-1:0]  frame_cnt;
    logic            overrun;
    logic            timeout_err;

    logic [3:0]      rrPend;
    logic [1:0]      rrPtr;
    logic [1:0]      rrPick;
    logic            rrValid;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] done;
        logic       anm;
        logic       endscreen;
        logic       pix;
        logic       clr;
        logic [3:0] eGnt;
        logic       eBusy;
        logic       eTick;
        logic [1:0] eFcnt;
        logic       eOvr;
        logic       eTo;
    } vec_t;

    vec_t vecs[$];

    vblank_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TCW(TCW), .FCW(FCW)) dut (
        .vgaclk      (vgaclk),
        .inputreset  (inputreset),
        .pixelstb    (pixelstb),
        .anm         (anm),
        .endscreen   (endscreen),
        .req         (req),
        .done        (done),
        .clr_err     (clr_err),
        .gnt         (gnt),
        .busy        (busy),
        .frame_tick  (frame_tick),
        .frame_cnt   (frame_cnt),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    rr_pick #(.NREQ(NREQ)) pickDut (
        .pend_i  (rrPend),
        .ptr_i   (rrPtr),
        .pick_o  (rrPick),
        .valid_o (rrValid)
    );

    initial vgaclk = 1'b0;
    always #5 vgaclk = ~vgaclk;

    task checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task checkAll(input string tag, input logic [3:0] eGnt, input logic eBusy, input logic eTick,
                  input logic [1:0] eFcnt, input logic eOvr, input logic eTo);
        checkOutput({tag, " gnt"}, 8'(gnt), 8'(eGnt));
        checkOutput({tag, " busy"}, 8'(busy), 8'(eBusy));
        checkOutput({tag, " frame_tick"}, 8'(frame_tick), 8'(eTick));
        checkOutput({tag, " frame_cnt"}, 8'(frame_cnt), 8'(eFcnt));
        checkOutput({tag, " overrun"}, 8'(overrun), 8'(eOvr));
        checkOutput({tag, " timeout_err"}, 8'(timeout_err), 8'(eTo));
    endtask

    task applyStimulus(input vec_t v);
        req       = v.req;
        done      = v.done;
        anm       = v.anm;
        endscreen = v.endscreen;
        pixelstb  = v.pix;
        clr_err   = v.clr;
    endtask

    task step;
        @(posedge vgaclk);
        #1;
    endtask

    task addVec(input logic [3:0] r, input logic [3:0] d, input logic a, input logic e,
                input logic p, input logic c, input logic [3:0] g, input logic b,
                input logic t, input logic [1:0] f, input logic o, input logic to);
        vec_t v;
        v.req = r; v.done = d; v.anm = a; v.endscreen = e; v.pix = p; v.clr = c;
        v.eGnt = g; v.eBusy = b; v.eTick = t; v.eFcnt = f; v.eOvr = o; v.eTo = to;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] dbl;
        logic [1:0] expPick;
        logic       expValid;
        int         cnt;

        inputreset = 1'b1;
        pixelstb   = 1'b1;
        anm        = 1'b0;
        endscreen  = 1'b0;
        req        = '0;
        done       = '0;
        clr_err    = 1'b0;
        rrPend     = '0;
        rrPtr      = '0;

        // Exhaustive check of the selector against a rotate-and-scan model.
        for (int p = 0; p < 16; p++) begin
            for (int q = 0; q < 4; q++) begin
                rrPend = 4'(p);
                rrPtr  = 2'(q);
                #1;
                dbl      = {rrPend, rrPend} >> (q + 1);
                expValid = 1'b0;
                expPick  = '0;
                for (int i = 0; i < 4; i++) begin
                    if (!expValid && dbl[i]) begin
                        expValid = 1'b1;
                        expPick  = 2'((q + 1 + i) % 4);
                    end
                end
                checkOutput($sformatf("rr valid p=%0h q=%0d", p, q), 8'(rrValid), 8'(expValid));
                if (expValid)
                    checkOutput($sformatf("rr pick p=%0h q=%0d", p, q), 8'(rrPick), 8'(expPick));
            end
        end

        checkAll("reset", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge vgaclk);
        inputreset = 1'b0;

        // Full-request window, an ignored unqualified anm, then a req=1010 window.
        addVec(4'hF, 4'h0, 1, 0, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0);
        addVec(4'hF, 4'h0, 1, 0, 1, 0, 4'h0, 1, 0, 2'd0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++)
                addVec(4'hF, 4'h0, 0, 0, 1, 0, 4'(1 << r), 1, 0, 2'd0, 0, 0);
            addVec(4'hF, 4'(1 << r), 0, 0, 1, 0, 4'h0, 1, 0, 2'd0, 0, 0);
        end
        addVec(4'hF, 4'h0, 0, 0, 1, 0, 4'h0, 0, 0, 2'd0, 0, 0);
        addVec(4'hF, 4'h0, 0, 1, 0, 0, 4'h0, 0, 0, 2'd0, 0, 0);
        addVec(4'hF, 4'h0, 0, 1, 1, 0, 4'h0, 0, 1, 2'd1, 0, 0);
        addVec(4'hA, 4'h0, 0, 0, 1, 0, 4'h0, 0, 0, 2'd1, 0, 0);
        addVec(4'hA, 4'h0, 1, 0, 1, 0, 4'h0, 1, 0, 2'd1, 0, 0);
        addVec(4'hA, 4'h0, 0, 0, 1, 0, 4'h2, 1, 0, 2'd1, 0, 0);
        addVec(4'hA, 4'h1, 0, 0, 1, 0, 4'h2, 1, 0, 2'd1, 0, 0);
        addVec(4'hA, 4'h0, 1, 0, 1, 0, 4'h2, 1, 0, 2'd1, 0, 0);
        addVec(4'h8, 4'h0, 0, 0, 1, 0, 4'h2, 1, 0, 2'd1, 0, 0);
        addVec(4'hA, 4'h2, 0, 0, 1, 0, 4'h0, 1, 0, 2'd1, 0, 0);
        addVec(4'hA, 4'h0, 0, 0, 1, 0, 4'h8, 1, 0, 2'd1, 0, 0);
        addVec(4'hA, 4'h8, 0, 0, 1, 0, 4'h0, 1, 0, 2'd1, 0, 0);
        addVec(4'hA, 4'h0, 0, 0, 1, 0, 4'h0, 0, 0, 2'd1, 0, 0);
        addVec(4'h0, 4'h0, 1, 0, 1, 0, 4'h0, 1, 0, 2'd1, 0, 0);
        addVec(4'h0, 4'h0, 0, 0, 1, 0, 4'h0, 0, 0, 2'd1, 0, 0);
        addVec(4'h0, 4'h0, 0, 1, 1, 0, 4'h0, 0, 1, 2'd2, 0, 0);
        addVec(4'h0, 4'h0, 0, 0, 1, 0, 4'h0, 0, 0, 2'd2, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            step;
            checkAll($sformatf("vec%0d", i), vecs[i].eGnt, vecs[i].eBusy, vecs[i].eTick,
                     vecs[i].eFcnt, vecs[i].eOvr, vecs[i].eTo);
        end
        anm = 1'b0; endscreen = 1'b0; done = '0; clr_err = 1'b0; pixelstb = 1'b1;

        // Requester 2 never finishes: grant must last exactly TIMEOUT cycles.
        req = 4'b1100;
        anm = 1'b1;
        step;
        anm = 1'b0;
        checkAll("to arb", 4'h0, 1, 0, 2'd2, 0, 0);
        step;
        checkAll("to grant", 4'h4, 1, 0, 2'd2, 0, 0);
        cnt = 1;
        for (int k = 0; k < 40; k++) begin
            step;
            if (gnt == 4'b0100) cnt++;
            else break;
        end
        checkOutput("to grant length", 8'(cnt), 8'(TIMEOUT));
        checkAll("to expired", 4'h0, 1, 0, 2'd2, 0, 1);
        step;
        checkAll("to next grant", 4'h8, 1, 0, 2'd2, 0, 1);
        done = 4'b1000;
        step;
        done = '0;
        checkAll("to done3", 4'h0, 1, 0, 2'd2, 0, 1);
        step;
        checkAll("to idle", 4'h0, 0, 0, 2'd2, 0, 1);
        clr_err = 1'b1;
        step;
        clr_err = 1'b0;
        checkAll("to clr", 4'h0, 0, 0, 2'd2, 0, 0);

        // Window closes while requester 1 holds the port.
        req = 4'hF;
        anm = 1'b1;
        step;
        anm = 1'b0;
        step;
        checkAll("ov grant0", 4'h1, 1, 0, 2'd2, 0, 0);
        done = 4'b0001;
        step;
        done = '0;
        step;
        checkAll("ov grant1", 4'h2, 1, 0, 2'd2, 0, 0);
        endscreen = 1'b1;
        step;
        endscreen = 1'b0;
        checkAll("ov abort", 4'h0, 0, 1, 2'd3, 1, 0);
        step;
        checkAll("ov after", 4'h0, 0, 0, 2'd3, 1, 0);
        req = 4'b0010;
        anm = 1'b1;
        step;
        anm = 1'b0;
        step;
        checkAll("ov regrant1", 4'h2, 1, 0, 2'd3, 1, 0);
        done = 4'b0010;
        step;
        done = '0;
        step;
        checkAll("ov idle", 4'h0, 0, 0, 2'd3, 1, 0);
        clr_err = 1'b1;
        step;
        clr_err = 1'b0;
        checkAll("ov clr", 4'h0, 0, 0, 2'd3, 0, 0);

        // anm and end in the same cycle: frame closes, no window opens.
        anm = 1'b1;
        endscreen = 1'b1;
        step;
        anm = 1'b0;
        endscreen = 1'b0;
        checkAll("both ev", 4'h0, 0, 1, 2'd0, 0, 0);
        step;
        checkAll("both after", 4'h0, 0, 0, 2'd0, 0, 0);

        // Frame counter wrap after a fresh reset.
        @(negedge vgaclk);
        inputreset = 1'b1;
        @(negedge vgaclk);
        inputreset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            endscreen = 1'b1;
            step;
            endscreen = 1'b0;
            checkAll($sformatf("wrap%0d", k), 4'h0, 0, 1, 2'(k % 4), 0, 0);
            step;
        end

        // Reset asserted mid-grant must drop gnt without a clock edge.
        req = 4'b0001;
        anm = 1'b1;
        step;
        anm = 1'b0;
        step;
        checkAll("pre reset", 4'h1, 1, 0, 2'd1, 0, 0);
        #2;
        inputreset = 1'b1;
        #1;
        checkAll("async reset", 4'h0, 0, 0, 2'd0, 0, 0);
        @(negedge vgaclk);
        inputreset = 1'b0;

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
